// File: rtl/operand_stack.sv
// -----------------------------------------------------------------------------
// operand_stack
//   LIFO data stack fed by the per-cycle push/pop strobes of control_module.
//   A push stores push_data on top of the stack; a pop returns the old top
//   one cycle later on pop_data/pop_valid as an operand for the datapath.
//   A simultaneous push and pop replaces the top entry.
//
// Ports
//   clk        in   system clock, all state updates on its rising edge
//   rst        in   synchronous active-high reset
//   push       in   push strobe, one cycle per push
//   pop        in   pop strobe, one cycle per pop
//   push_data  in   value stored on an accepted push
//   top        out  combinational top entry, 0 when empty
//   pop_data   out  registered value removed by the last accepted pop
//   pop_valid  out  one-cycle pulse: pop_data holds a newly popped value
//   count      out  number of valid entries, 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
//   overflow   out  sticky, set by a push rejected because the stack is full
//   underflow  out  sticky, set by a pop rejected because the stack is empty
//
// Strobe semantics: push and pop are single-cycle requests with no
// back-pressure. A request that cannot be honoured is dropped and recorded in
// the matching sticky flag; the producer is expected to watch full/empty.
// -----------------------------------------------------------------------------
module operand_stack #(
  parameter int VALUE_WIDTH = 8,
  parameter int DEPTH       = 8,
  parameter int PTR_WIDTH   = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [VALUE_WIDTH-1:0] push_data,
  output logic [VALUE_WIDTH-1:0] top,
  output logic [VALUE_WIDTH-1:0] pop_data,
  output logic                   pop_valid,
  output logic [PTR_WIDTH-1:0]   count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int IDX_WIDTH = PTR_WIDTH - 1;

  // Occupancy classes derived from the pointer; kept as a named signal so
  // checkers can bind to it.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } stack_state_t;

  logic [VALUE_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]   r_count;
  logic [VALUE_WIDTH-1:0] r_pop_data;
  logic                   r_pop_valid;
  logic                   r_overflow;
  logic                   r_underflow;

  logic [PTR_WIDTH-1:0]   w_count_m1;
  logic [IDX_WIDTH-1:0]   w_top_idx;
  logic [IDX_WIDTH-1:0]   w_wr_idx;
  logic                   w_empty;
  logic                   w_full;
  logic [VALUE_WIDTH-1:0] w_top_val;
  stack_state_t           w_state;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == PTR_WIDTH'(DEPTH));
  assign w_count_m1 = r_count - PTR_WIDTH'(1);
  // Only meaningful when not empty; the low bits index the top entry.
  assign w_top_idx  = w_count_m1[IDX_WIDTH-1:0];
  // Only used when not full, so count < DEPTH fits in the index width.
  assign w_wr_idx   = r_count[IDX_WIDTH-1:0];
  assign w_top_val  = r_mem[w_top_idx];

  always_comb begin
    w_state = ST_PARTIAL;
    if (w_empty)     w_state = ST_EMPTY;
    else if (w_full) w_state = ST_FULL;
  end

  // Storage: no reset, contents are don't-care after rst. Writes are blocked
  // while rst is high so reset wins over a same-cycle push.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      if (pop) begin
        // Replace the top, or on an empty stack the push lands in slot 0.
        if (w_empty) r_mem[0]         <= push_data;
        else         r_mem[w_top_idx] <= push_data;
      end else if (!w_full) begin
        r_mem[w_wr_idx] <= push_data;
      end
    end
  end

  // Pointer, pop result and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      case ({push, pop})
        2'b11: begin
          if (w_empty) begin
            // Pop half is rejected, push half still executes.
            r_underflow <= 1'b1;
            r_count     <= PTR_WIDTH'(1);
          end else begin
            // Replace: count is unchanged, so a full stack cannot overflow.
            r_pop_data  <= w_top_val;
            r_pop_valid <= 1'b1;
          end
        end
        2'b10: begin
          if (w_full) r_overflow <= 1'b1;
          else        r_count    <= r_count + PTR_WIDTH'(1);
        end
        2'b01: begin
          if (w_empty) begin
            r_underflow <= 1'b1;
          end else begin
            r_pop_data  <= w_top_val;
            r_pop_valid <= 1'b1;
            r_count     <= w_count_m1;
          end
        end
        default: ;
      endcase
    end
  end

  assign top       = w_empty ? '0 : w_top_val;
  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_operand_stack.sv
module tb_operand_stack;

  localparam int VW = 8;
  localparam int DP = 8;
  localparam int PW = $clog2(DP) + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [VW-1:0] push_data = '0;
  logic [VW-1:0] top;
  logic [VW-1:0] pop_data;
  logic          pop_valid;
  logic [PW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_stack #(.VALUE_WIDTH(VW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top       (top),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change 1 ns after the rising edge, outputs are
  // sampled 1 ns after the edge that consumed them.
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic p, input logic q, input logic [VW-1:0] d);
    push = p; pop = q; push_data = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    checks++; if (count !== 4'd0)     begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)     begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (full !== 1'b0)      begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (top !== 8'h00)      begin failures++; $display("FAIL reset_top got=%0h exp=0", top); end
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL reset_pop_valid got=%0b exp=0", pop_valid); end
    checks++; if (pop_data !== 8'h00) begin failures++; $display("FAIL reset_pop_data got=%0h exp=0", pop_data); end
    checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%0b exp=0", underflow); end
  endtask

  task automatic test_lifo();
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] vals[3];
    logic [VW-1:0] e;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, vals[i]);
      exp_q.push_back(vals[i]);
      checks++; if (top !== vals[i]) begin failures++; $display("FAIL lifo_top_after_push%0d got=%0h exp=%0h", i, top, vals[i]); end
    end
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL lifo_count3 got=%0d exp=3", count); end
    // Three back-to-back pops: pop_valid stays high each cycle.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, '0);
      e = exp_q.pop_back();
      checks++; if (pop_data !== e)     begin failures++; $display("FAIL lifo_pop_data%0d got=%0h exp=%0h", i, pop_data, e); end
      checks++; if (pop_valid !== 1'b1) begin failures++; $display("FAIL lifo_pop_valid%0d got=%0b exp=1", i, pop_valid); end
    end
    cycle(1'b0, 1'b0, '0);
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL lifo_valid_drop got=%0b exp=0", pop_valid); end
    checks++; if (pop_data !== 8'h11) begin failures++; $display("FAIL lifo_pop_data_hold got=%0h exp=11", pop_data); end
    checks++; if (count !== 4'd0)     begin failures++; $display("FAIL lifo_count_end got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)     begin failures++; $display("FAIL lifo_empty_end got=%0b exp=1", empty); end
    checks++; if (top !== 8'h00)      begin failures++; $display("FAIL lifo_top_end got=%0h exp=0", top); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i));
    checks++; if (full !== 1'b1)      begin failures++; $display("FAIL full_flag got=%0b exp=1", full); end
    checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL full_no_ovf_yet got=%0b exp=0", overflow); end
    cycle(1'b1, 1'b0, 8'h99);
    checks++; if (count !== 4'd8)     begin failures++; $display("FAIL full_count got=%0d exp=8", count); end
    checks++; if (overflow !== 1'b1)  begin failures++; $display("FAIL full_overflow got=%0b exp=1", overflow); end
    checks++; if (top !== 8'h08)      begin failures++; $display("FAIL full_top got=%0h exp=08", top); end
    checks++; if (empty !== 1'b0)     begin failures++; $display("FAIL full_empty got=%0b exp=0", empty); end
    // Replace on a full stack: no overflow side effect, count unchanged.
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
    cycle(1'b1, 1'b1, 8'hAB);
    checks++; if (pop_data !== 8'h48) begin failures++; $display("FAIL full_repl_pop_data got=%0h exp=48", pop_data); end
    checks++; if (top !== 8'hAB)      begin failures++; $display("FAIL full_repl_top got=%0h exp=ab", top); end
    checks++; if (count !== 4'd8)     begin failures++; $display("FAIL full_repl_count got=%0d exp=8", count); end
    checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL full_repl_overflow got=%0b exp=0", overflow); end
    // Drain fully and check the LIFO order below the replaced top.
    for (int i = 7; i >= 1; i--) begin
      cycle(1'b0, 1'b1, '0);
      if (i == 7) cycle(1'b0, 1'b0, '0);
    end
    cycle(1'b0, 1'b1, '0);
    checks++; if (pop_data !== 8'h41) begin failures++; $display("FAIL full_drain_last got=%0h exp=41", pop_data); end
    checks++; if (empty !== 1'b1)     begin failures++; $display("FAIL full_drain_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_underflow();
    do_reset();
    cycle(1'b0, 1'b1, '0);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_flag got=%0b exp=1", underflow); end
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL unf_pop_valid got=%0b exp=0", pop_valid); end
    checks++; if (count !== 4'd0)     begin failures++; $display("FAIL unf_count got=%0d exp=0", count); end
    checks++; if (pop_data !== 8'h00) begin failures++; $display("FAIL unf_pop_data got=%0h exp=0", pop_data); end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%0b exp=1", underflow); end
    do_reset();
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL unf_cleared got=%0b exp=0", underflow); end
  endtask

  task automatic test_replace();
    do_reset();
    cycle(1'b1, 1'b0, 8'h05);
    cycle(1'b1, 1'b1, 8'h0A);
    checks++; if (pop_data !== 8'h05) begin failures++; $display("FAIL repl_pop_data got=%0h exp=05", pop_data); end
    checks++; if (pop_valid !== 1'b1) begin failures++; $display("FAIL repl_pop_valid got=%0b exp=1", pop_valid); end
    checks++; if (top !== 8'h0A)      begin failures++; $display("FAIL repl_top got=%0h exp=0a", top); end
    checks++; if (count !== 4'd1)     begin failures++; $display("FAIL repl_count got=%0d exp=1", count); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL repl_underflow got=%0b exp=0", underflow); end
    // Same strobe pair on an empty stack.
    do_reset();
    cycle(1'b1, 1'b1, 8'h3C);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL repl_empty_underflow got=%0b exp=1", underflow); end
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL repl_empty_pop_valid got=%0b exp=0", pop_valid); end
    checks++; if (count !== 4'd1)     begin failures++; $display("FAIL repl_empty_count got=%0d exp=1", count); end
    checks++; if (top !== 8'h3C)      begin failures++; $display("FAIL repl_empty_top got=%0h exp=3c", top); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b1, 1'b0, 8'hA1);
    cycle(1'b1, 1'b0, 8'hA2);
    cycle(1'b1, 1'b0, 8'hA3);
    cycle(1'b1, 1'b0, 8'hA4);
    cycle(1'b0, 1'b1, '0);
    checks++; if (pop_data !== 8'hA4) begin failures++; $display("FAIL mid_pre_pop got=%0h exp=a4", pop_data); end
    cycle(1'b1, 1'b0, 8'hA4);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 8'h77);
    rst = 1'b0;
    checks++; if (count !== 4'd0)     begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)     begin failures++; $display("FAIL mid_empty got=%0b exp=1", empty); end
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL mid_pop_valid got=%0b exp=0", pop_valid); end
    checks++; if (pop_data !== 8'h00) begin failures++; $display("FAIL mid_pop_data got=%0h exp=0", pop_data); end
    checks++; if (top !== 8'h00)      begin failures++; $display("FAIL mid_top got=%0h exp=0", top); end
    // The pushed value was not stored: a pop now underflows.
    cycle(1'b0, 1'b1, '0);
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL mid_not_stored got=%0b exp=1", underflow); end
  endtask

  task automatic test_back_to_back();
    // Push, pop, push, pop alternating: pop_valid pulses only after pops.
    do_reset();
    cycle(1'b1, 1'b0, 8'h5A);
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_after_push got=%0b exp=0", pop_valid); end
    cycle(1'b0, 1'b1, '0);
    checks++; if (pop_data !== 8'h5A) begin failures++; $display("FAIL b2b_pop1 got=%0h exp=5a", pop_data); end
    cycle(1'b1, 1'b0, 8'hC3);
    checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%0b exp=0", pop_valid); end
    checks++; if (top !== 8'hC3)      begin failures++; $display("FAIL b2b_top got=%0h exp=c3", top); end
    cycle(1'b0, 1'b1, '0);
    checks++; if (pop_data !== 8'hC3) begin failures++; $display("FAIL b2b_pop2 got=%0h exp=c3", pop_data); end
    checks++; if (pop_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid2 got=%0b exp=1", pop_valid); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_lifo();
    test_full();
    test_underflow();
    test_replace();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
- LIFO data stack that consumes the push/pop strobes issued by control_module each cycle.
- On push it stores the value selected for the stack destination. On pop it returns the stack top as an operand for the datapath.
- Sits directly downstream of control_module, in parallel with the ALU / register file.
- Reports full, empty and sticky error status for debug and for the test benches.

Parameters:
VALUE_WIDTH, 8, width of each stack entry and of the data ports
DEPTH, 8, number of entries; must be a power of two and at least 2
PTR_WIDTH, $clog2(DEPTH)+1, width of the count output (holds 0..DEPTH)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk
push  input  1  push request from control_module, one cycle per push
pop  input  1  pop request from control_module, one cycle per pop
push_data  input  VALUE_WIDTH  value to store on push
top  output  VALUE_WIDTH  current top entry, combinational read of storage; 0 when empty
pop_data  output  VALUE_WIDTH  registered value removed by the last accepted pop
pop_valid  output  1  high for exactly one cycle when pop_data holds a newly popped value
count  output  PTR_WIDTH  number of valid entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky; set on a rejected push
underflow  output  1  sticky; set on a rejected pop

Behaviour:
- Reset: when rst is high at a clock edge, the following are cleared:
  - count, pop_data, pop_valid, overflow, underflow all go to 0.
  - empty=1, full=0, top=0.
  - Storage contents are don't-care.
  - Reset wins over any push or pop in the same cycle, including mid-sequence.
- Storage: DEPTH x VALUE_WIDTH register array. Stack pointer sp = count; the top entry lives at index count-1.
- Push only (push=1, pop=0):
  - Not full: mem[count] <= push_data, count+1. top shows the new value in the following cycle.
  - Full: push rejected, storage and count unchanged, overflow <= 1.
- Pop only (push=0, pop=1):
  - Not empty: pop_data <= mem[count-1], pop_valid <= 1, count-1. Latency is 1 cycle: pop_data/pop_valid are valid in the cycle after the pop strobe.
  - Empty: pop rejected, pop_valid <= 0, pop_data unchanged, underflow <= 1.
- Push and pop in the same cycle:
  - Not empty (including full): replace the top. pop_data <= old top, pop_valid <= 1, mem[count-1] <= push_data, count unchanged. No overflow.
  - Empty: underflow <= 1, pop_valid <= 0, then the push executes: mem[0] <= push_data, count becomes 1.
- Idle (push=0, pop=0): pop_valid <= 0; all other state holds.
- pop_valid is never high for two consecutive cycles unless there are two consecutive accepted pops.
- overflow and underflow stay at 1 until rst is asserted.
- count never exceeds DEPTH and never wraps below 0.
- No internal FSM beyond the pointer. The states are EMPTY (count=0), PARTIAL and FULL (count=DEPTH), derived from count.

Test Plan:
- Reset then idle 3 cycles -> count=0, empty=1, full=0, top=0, pop_valid=0, overflow=0, underflow=0.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times -> top=0x33 after the pushes. pop_data sequence is 0x33, 0x22, 0x11, each with a 1-cycle pop_valid. count ends at 0 and empty=1.
- Push 8 values 0x01..0x08 (DEPTH=8), then push 0x99 -> full=1, count=8, overflow=1, top remains 0x08.
- Pop on an empty stack -> underflow=1, pop_valid=0, count=0. The flag is still 1 ten cycles later and clears only after rst.
- With stack holding 0x05 (count=1), assert push=1, pop=1, push_data=0x0A -> next cycle pop_data=0x05, pop_valid=1, top=0x0A, count=1. Then the same strobe pair on an empty stack -> underflow=1, count=1, top=push_data.
- Push 4 values, then assert rst together with push=1 -> next cycle count=0, empty=1, pop_valid=0, and the pushed value is not stored.
